snn_lif_layer: RTL and testbench

Parametrised layer of leaky integrate-and-fire (LIF) spiking neurons. It extends the fixed two-input threshold summer to N_IN inputs and N_OUT neurons, with programmable signed weights, membrane leak, a refractory period and reward-modulated weight learning. It sits between the input pin decoder and the output spike encoder. Each accepted input vector is one network timestep.

---
 rtl/snn_lif_layer_if.sv | 25 ++
 rtl/snn_lif_layer.sv | 142 ++++++++++++++
 tb/tb_snn_lif_layer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_lif_layer_if.sv
// snn_lif_layer_if: input/output handshakes, reward pulse and weight port of snn_lif_layer
interface snn_lif_layer_if #(
    parameter int N_IN = 2,
    parameter int N_OUT = 2,
    parameter int WIDTH = 4,
    parameter int WW = 4,
    parameter int IW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
);
    logic in_valid;
    logic in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [N_OUT-1:0] out_spike;
    logic reward_valid;
    logic reward_sign;
    logic w_we;
    logic [IW-1:0] w_addr;
    logic [WW-1:0] w_wdata;
    logic [WW-1:0] w_rdata;
    modport master(output in_valid, in_data, out_ready, reward_valid, reward_sign, w_we, w_addr, w_wdata,
                   input in_ready, out_valid, out_spike, w_rdata);
    modport slave(input in_valid, in_data, out_ready, reward_valid, reward_sign, w_we, w_addr, w_wdata,
                  output in_ready, out_valid, out_spike, w_rdata);
endinterface

// File: rtl/snn_lif_layer.sv
// snn_lif_layer: layer of leaky integrate-and-fire neurons with refractory period and weight port.
// Reward-modulated learning (traces, pending flag, REWARD state) is built only when SNN_REWARD_EN is defined.
module snn_lif_layer #(
    parameter int N_IN = 2,
    parameter int N_OUT = 2,
    parameter int WIDTH = 4,
    parameter int VW = 8,
    parameter int WW = 4,
    parameter int W_INIT = 1,
    parameter int THRESH = 16,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRAC = 2,
    parameter int TRACE = 3
) (
    input logic clk,
    input logic rst,
    snn_lif_layer_if.slave bus
);
    localparam int NW = N_IN * N_OUT;
    localparam int IW = NW > 1 ? $clog2(NW) : 1;
    localparam int KW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int AW = WIDTH + WW + $clog2(N_IN) + 1;
    localparam int SW = (AW > VW ? AW : VW) + 2;
    localparam int RW = $clog2(REFRAC + 2);
    localparam int TW = $clog2(TRACE + 2);
    localparam logic [VW-1:0] TH = VW'(THRESH);
    localparam logic signed [SW-1:0] VMAX = SW'((1 << VW) - 1);
    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACC, FIRE, OUT, REWARD} state_t;
    state_t state;
    logic [N_IN*WIDTH-1:0] data;
    logic [KW-1:0] k;
    logic signed [AW-1:0] xin;
    logic signed [WW-1:0] w [NW];
    logic [N_OUT-1:0] spike;
    logic pending, sign, go;

    assign go = state == IDLE && !pending && bus.in_valid;
    assign xin = AW'(data[k*WIDTH +: WIDTH]);
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == OUT;
    assign bus.out_spike = spike;
    assign bus.w_rdata = w[bus.w_addr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            data <= '0;
            k <= '0;
        end else begin
            if (go) data <= bus.in_data;
            k <= state == ACC ? k + KW'(1) : '0;
            case (state)
                IDLE: state <= pending ? REWARD : bus.in_valid ? ACC : IDLE;
                ACC: state <= k == KW'(N_IN - 1) ? FIRE : ACC;
                FIRE: state <= OUT;
                OUT: state <= bus.out_ready ? IDLE : OUT;
                default: state <= IDLE;
            endcase
        end

`ifdef SNN_REWARD_EN
    logic [TW-1:0] pre [N_IN];
    logic [TW-1:0] post [N_OUT];
    // Several pulses before service collapse into one; the last sign wins.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pending <= 1'b0;
            sign <= 1'b0;
        end else if (bus.reward_valid) begin
            pending <= 1'b1;
            sign <= bus.reward_sign;
        end else if (state == REWARD) pending <= 1'b0;
    for (genvar i = 0; i < N_IN; i++) begin : g_pre
        logic [TW-1:0] t;
        always_ff @(posedge clk or posedge rst)
            if (rst) t <= '0;
            else if (state == FIRE) t <= |data[i*WIDTH +: WIDTH] ? TW'(TRACE) : t - TW'(|t);
        assign pre[i] = t;
    end
`else
    logic unused_reward;
    assign unused_reward = bus.reward_valid ^ bus.reward_sign;
    assign pending = 1'b0;
    assign sign = 1'b0;
`endif

    for (genvar j = 0; j < N_OUT; j++) begin : g_n
        logic signed [AW-1:0] acc, prod, wext;
        logic signed [SW-1:0] sum;
        logic [VW-1:0] v, leaked, v_nxt;
        logic [RW-1:0] refrac;
        logic [IW-1:0] idx;
        logic spk, fire;
        assign idx = IW'(j * N_IN) + IW'(k);
        assign wext = AW'(w[idx]);
        assign prod = xin * wext;
        assign leaked = v - (v >> LEAK_SHIFT);
        assign sum = $signed(SW'(leaked)) + SW'(acc);
        // Refractory neurons only leak; their input for this step is dropped.
        assign v_nxt = |refrac ? leaked : sum[SW-1] ? '0 : sum > VMAX ? '1 : sum[VW-1:0];
        assign fire = ~|refrac && v_nxt >= TH;
        assign spike[j] = spk;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                acc <= '0;
                v <= '0;
                refrac <= '0;
                spk <= 1'b0;
            end else if (state == FIRE) begin
                v <= fire ? '0 : v_nxt;
                refrac <= fire ? RW'(REFRAC) : refrac - RW'(|refrac);
                spk <= fire;
            end else if (state == ACC) acc <= acc + prod;
            else if (go) acc <= '0;
`ifdef SNN_REWARD_EN
        logic [TW-1:0] pt;
        always_ff @(posedge clk or posedge rst)
            if (rst) pt <= '0;
            else if (state == FIRE) pt <= fire ? TW'(TRACE) : pt - TW'(|pt);
        assign post[j] = pt;
`endif
    end

    for (genvar n = 0; n < NW; n++) begin : g_w
        logic signed [WW-1:0] r;
        logic up;
`ifdef SNN_REWARD_EN
        assign up = state == REWARD && |pre[n % N_IN] && |post[n / N_IN];
`else
        assign up = 1'b0;
`endif
        // A port write beats a simultaneous reward update to the same weight.
        always_ff @(posedge clk or posedge rst)
            if (rst) r <= WW'(W_INIT);
            else if (bus.w_we && bus.w_addr == IW'(n)) r <= bus.w_wdata;
            else if (up) r <= sign ? (r == WMAX ? r : r + WW'(1)) : (r == WMIN ? r : r - WW'(1));
        assign w[n] = r;
    end
endmodule

// File: tb/tb_snn_lif_layer.sv
// tb_snn_lif_layer: directed and randomized checks of snn_lif_layer against an arithmetic model
module tb_snn_lif_layer;
    localparam int N_IN = 2, N_OUT = 2, WIDTH = 4, VW = 8, WW = 4, W_INIT = 1;
    localparam int THRESH = 16, LEAK_SHIFT = 2, REFRAC = 2, TRACE = 3;
    localparam int NW = N_IN * N_OUT;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    snn_lif_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .WW(WW)) bus();
    snn_lif_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .VW(VW), .WW(WW), .W_INIT(W_INIT),
                    .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC), .TRACE(TRACE))
        dut(.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;
    int mv [N_OUT], mref [N_OUT], mpost [N_OUT], mpre [N_IN], mw [NW];

    function automatic void model_reset();
        for (int j = 0; j < N_OUT; j++) begin mv[j] = 0; mref[j] = 0; mpost[j] = 0; end
        for (int i = 0; i < N_IN; i++) mpre[i] = 0;
        for (int n = 0; n < NW; n++) mw[n] = W_INIT;
    endfunction

    function automatic logic [N_OUT-1:0] model_step(logic [N_IN*WIDTH-1:0] d);
        logic [N_OUT-1:0] s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            int a, lk, nv;
            a = 0;
            for (int i = 0; i < N_IN; i++) a += int'(d[i*WIDTH +: WIDTH]) * mw[j*N_IN + i];
            lk = mv[j] - mv[j] / (1 << LEAK_SHIFT);
            if (mref[j] > 0) begin
                mv[j] = lk;
                mref[j]--;
                if (mpost[j] > 0) mpost[j]--;
            end else begin
                nv = lk + a;
                if (nv < 0) nv = 0;
                if (nv > (1 << VW) - 1) nv = (1 << VW) - 1;
                if (nv >= THRESH) begin
                    s[j] = 1'b1; mv[j] = 0; mref[j] = REFRAC; mpost[j] = TRACE;
                end else begin
                    mv[j] = nv;
                    if (mpost[j] > 0) mpost[j]--;
                end
            end
        end
        for (int i = 0; i < N_IN; i++)
            mpre[i] = d[i*WIDTH +: WIDTH] != 0 ? TRACE : (mpre[i] > 0 ? mpre[i] - 1 : 0);
        return s;
    endfunction

    function automatic void model_reward(logic s);
`ifdef SNN_REWARD_EN
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                if (mpre[i] > 0 && mpost[j] > 0) begin
                    mw[j*N_IN + i] += s ? 1 : -1;
                    if (mw[j*N_IN + i] > 7) mw[j*N_IN + i] = 7;
                    if (mw[j*N_IN + i] < -8) mw[j*N_IN + i] = -8;
                end
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.reward_valid = 1'b0; bus.w_we = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic do_step(input logic [N_IN*WIDTH-1:0] d, output logic [N_OUT-1:0] spk,
                           output logic [N_OUT-1:0] exp_spk, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        bus.in_valid = 1'b1; bus.in_data = d;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin tick(); lat++; end
        spk = bus.out_spike;
        exp_spk = model_step(d);
    endtask

    task automatic wr(input int a, input int val);
        bus.w_we = 1'b1; bus.w_addr = 2'(a); bus.w_wdata = WW'(val);
        tick();
        bus.w_we = 1'b0;
        mw[a] = val;
    endtask

    task automatic pulse_reward(input logic s);
        bus.reward_valid = 1'b1; bus.reward_sign = s;
        tick();
        bus.reward_valid = 1'b0;
        tick(); tick(); tick();
        model_reward(s);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_spike !== 2'b00) begin bad++; $display("FAIL reset_out_spike got=%b exp=00", bus.out_spike); end
        for (int a = 0; a < NW; a++) begin
            bus.w_addr = 2'(a);
            #1;
            total++; if (bus.w_rdata !== 4'd1) begin bad++; $display("FAIL reset_weight[%0d] got=%0d exp=1", a, bus.w_rdata); end
        end
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        tick(); tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid_step got in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        end
        do_reset();
    endtask

    task automatic test_fire();
        logic [N_OUT-1:0] s, e;
        int lat;
        do_reset();
        do_step(8'hFF, s, e, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL fire_latency got=%0d exp=3", lat); end
        total++; if (s !== 2'b11 || s !== e) begin bad++; $display("FAIL fire_spike got=%b exp=11 model=%b", s, e); end
    endtask

    task automatic test_leak();
        logic [N_OUT-1:0] s, e;
        logic [7:0] seq [4] = '{8'h05, 8'h00, 8'h00, 8'hF0};
        logic [1:0] want [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
        int lat;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            do_step(seq[t], s, e, lat);
            total++; if (s !== want[t] || s !== e) begin bad++; $display("FAIL leak_step%0d got=%b exp=%b model=%b", t, s, want[t], e); end
        end
    endtask

    task automatic test_refrac();
        logic [N_OUT-1:0] s, e;
        logic [1:0] want [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
        int lat;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            do_step(8'hFF, s, e, lat);
            total++; if (s !== want[t] || s !== e) begin bad++; $display("FAIL refrac_step%0d got=%b exp=%b model=%b", t, s, want[t], e); end
        end
    endtask

    task automatic test_reward();
        logic [N_OUT-1:0] s, e;
        int lat, up, low;
        int ch [NW];
`ifdef SNN_REWARD_EN
        up = 2; low = -8; ch = '{3, 1, 3, 1};
`else
        up = 1; low = 1; ch = '{2, 1, 2, 1};
`endif
        do_reset();
        do_step(8'hFF, s, e, lat);
        pulse_reward(1'b1);
        for (int a = 0; a < NW; a++) begin
            bus.w_addr = 2'(a); #1;
            total++; if (bus.w_rdata !== WW'(up) || bus.w_rdata !== WW'(mw[a])) begin bad++; $display("FAIL reward_up[%0d] got=%0d exp=%0d", a, $signed(bus.w_rdata), up); end
        end
        for (int p = 0; p < 12; p++) pulse_reward(1'b0);
        for (int a = 0; a < NW; a++) begin
            bus.w_addr = 2'(a); #1;
            total++; if (bus.w_rdata !== WW'(low) || bus.w_rdata !== WW'(mw[a])) begin bad++; $display("FAIL reward_sat[%0d] got=%0d exp=%0d", a, $signed(bus.w_rdata), low); end
        end
        do_reset();
        wr(0, 2); wr(2, 2);
        for (int t = 0; t < 3; t++) do_step(8'h0F, s, e, lat);
        pulse_reward(1'b1);
        for (int a = 0; a < NW; a++) begin
            bus.w_addr = 2'(a); #1;
            total++; if (bus.w_rdata !== WW'(ch[a]) || bus.w_rdata !== WW'(mw[a])) begin bad++; $display("FAIL reward_idle_chan[%0d] got=%0d exp=%0d", a, $signed(bus.w_rdata), ch[a]); end
        end
    endtask

    task automatic test_backpressure();
        logic [N_OUT-1:0] s, e;
        int lat;
        do_reset();
        bus.out_ready = 1'b0;
        do_step(8'hFF, s, e, lat);
        total++; if (s !== 2'b11) begin bad++; $display("FAIL bp_first got=%b exp=11", s); end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'h00;
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_spike !== 2'b11 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got valid=%b spike=%b ready=%b exp=1/11/0", c, bus.out_valid, bus.out_spike, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got ready=%b valid=%b exp=1/0", bus.in_ready, bus.out_valid); end
        do_step(8'hFF, s, e, lat);
        total++; if (s !== 2'b00 || s !== e) begin bad++; $display("FAIL bp_after got=%b exp=00 model=%b", s, e); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        do_reset();
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid) cnt++;
        end
        bus.in_valid = 1'b0;
        total++; if (cnt !== 4) begin bad++; $display("FAIL back_to_back_outputs got=%0d exp=4", cnt); end
    endtask

    task automatic test_random();
        logic [N_OUT-1:0] s, e;
        logic [7:0] d;
        int lat;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) wr($urandom_range(0, NW - 1), $urandom_range(0, 15) - 8);
            if ($urandom_range(0, 4) == 0) pulse_reward(1'($urandom_range(0, 1)));
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[3:0] = 4'h0;
            if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
            do_step(d, s, e, lat);
            total++; if (lat >= 20 || s !== e) begin bad++; $display("FAIL random_step%0d in=%h got=%b exp=%b lat=%0d", t, d, s, e, lat); end
        end
        for (int a = 0; a < NW; a++) begin
            bus.w_addr = 2'(a); #1;
            total++; if (bus.w_rdata !== WW'(mw[a])) begin bad++; $display("FAIL random_weight[%0d] got=%0d exp=%0d", a, $signed(bus.w_rdata), mw[a]); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; bus.reward_valid = 1'b0;
        bus.reward_sign = 1'b0; bus.w_we = 1'b0; bus.w_addr = '0; bus.w_wdata = '0;
        test_reset();
        test_fire();
        test_leak();
        test_refrac();
        test_reward();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
